// File: rtl/alu_exec_unit.sv
// Integer execution unit: computes one issued ALU op per cycle and queues tagged results
// in an in-order FIFO until the CDB arbiter grants a broadcast slot.
module alu_exec_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        flag_alu,
  input  logic [5:0]  op_alu,
  input  logic [31:0] rs1_alu,
  input  logic [31:0] rs2_alu,
  input  logic [3:0]  rob_alu,
  input  logic        cdb_grant,
  output logic        alu_full,
  output logic        alu_ans_flag,
  output logic [3:0]  alu_ans_reorder,
  output logic [31:0] alu_ans
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     res;
  logic [31:0]     sum;
  logic [31:0]     val_q [DEPTH];
  logic [3:0]      tag_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [31:0]     ans_q, ans_d;
  logic [3:0]      reorder_q, reorder_d;
  logic            do_push, do_pop;

  assign sum = rs1_alu + rs2_alu;

  always_comb begin
    res = '0;
    case (op_alu)
      6'd0:  res = sum;
      6'd1:  res = rs1_alu - rs2_alu;
      6'd2:  res = rs1_alu << rs2_alu[4:0];
      6'd3:  res = {31'd0, $signed(rs1_alu) < $signed(rs2_alu)};
      6'd4:  res = {31'd0, rs1_alu < rs2_alu};
      6'd5:  res = rs1_alu ^ rs2_alu;
      6'd6:  res = rs1_alu >> rs2_alu[4:0];
      6'd7:  res = $signed(rs1_alu) >>> rs2_alu[4:0];
      6'd8:  res = rs1_alu | rs2_alu;
      6'd9:  res = rs1_alu & rs2_alu;
      6'd10: res = {31'd0, rs1_alu == rs2_alu};
      6'd11: res = {31'd0, rs1_alu != rs2_alu};
      6'd12: res = {31'd0, $signed(rs1_alu) < $signed(rs2_alu)};
      6'd13: res = {31'd0, $signed(rs1_alu) >= $signed(rs2_alu)};
      6'd14: res = {31'd0, rs1_alu < rs2_alu};
      6'd15: res = {31'd0, rs1_alu >= rs2_alu};
      6'd16: res = sum & ~32'd1;
      default: res = '0;
    endcase
  end

  // Pop reads pre-edge state, so a same-edge push is never bypassed to the output.
  assign do_pop  = rdy && !clr && cdb_grant && (cnt_q != '0);
  // A push into a completely full FIFO is dropped unless a pop frees the slot this edge.
  assign do_push = rdy && !clr && flag_alu && ((cnt_q != CntW'(DEPTH)) || do_pop);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    ans_d     = ans_q;
    reorder_d = reorder_q;
    if (rdy) begin
      flag_d = 1'b0;
      if (clr) begin
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
      end else begin
        if (do_pop) begin
          head_d    = head_q + PtrW'(1);
          flag_d    = 1'b1;
          ans_d     = val_q[head_q];
          reorder_d = tag_q[head_q];
        end
        if (do_push) begin
          tail_d = tail_q + PtrW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   cnt_d = cnt_q + CntW'(1);
          2'b01:   cnt_d = cnt_q - CntW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      ans_q     <= '0;
      reorder_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      ans_q     <= ans_d;
      reorder_q <= reorder_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      val_q[tail_q] <= res;
      tag_q[tail_q] <= rob_alu;
    end
  end

  // One slot stays free for the op already in flight from the RS.
  assign alu_full        = cnt_q >= CntW'(DEPTH - 1);
  assign alu_ans_flag    = flag_q;
  assign alu_ans         = ans_q;
  assign alu_ans_reorder = reorder_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver queues expected tagged results, monitor
// compares every fresh CDB broadcast against the queue head.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, flag_alu, cdb_grant;
  logic [5:0]  op_alu;
  logic [31:0] rs1_alu, rs2_alu;
  logic [3:0]  rob_alu;
  logic        alu_full, alu_ans_flag;
  logic [3:0]  alu_ans_reorder;
  logic [31:0] alu_ans;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];
  logic        rdy_e, rst_e;
  logic [35:0] ent;

  alu_exec_unit #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .clr             (clr),
    .flag_alu        (flag_alu),
    .op_alu          (op_alu),
    .rs1_alu         (rs1_alu),
    .rs2_alu         (rs2_alu),
    .rob_alu         (rob_alu),
    .cdb_grant       (cdb_grant),
    .alu_full        (alu_full),
    .alu_ans_flag    (alu_ans_flag),
    .alu_ans_reorder (alu_ans_reorder),
    .alu_ans         (alu_ans)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp);
    flag_alu = 1'b1;
    op_alu   = op;
    rs1_alu  = a;
    rs2_alu  = b;
    rob_alu  = tag;
    sb.push_back({tag, exp});
    @(negedge clk);
    flag_alu = 1'b0;
  endtask

  // Monitor: a broadcast is fresh only if the preceding edge had rdy high and no reset.
  always @(posedge clk) begin
    rdy_e = rdy;
    rst_e = rst;
    #1;
    if (!rst_e && rdy_e && alu_ans_flag) begin
      if (sb.size() == 0) begin
        check("spurious_bcast", {31'd0, alu_ans_flag}, 32'd0);
      end else begin
        ent = sb.pop_front();
        check("bcast_tag", {28'd0, alu_ans_reorder}, {28'd0, ent[35:32]});
        check("bcast_val", alu_ans, ent[31:0]);
      end
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{6'd7,  32'h8000_0000, 32'd36,        32'hF800_0000};
    vecs[1]  = '{6'd6,  32'h8000_0000, 32'd36,        32'h0800_0000};
    vecs[2]  = '{6'd1,  32'd0,         32'd1,         32'hFFFF_FFFF};
    vecs[3]  = '{6'd14, 32'd1,         32'hFFFF_FFFF, 32'd1};
    vecs[4]  = '{6'd12, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vecs[5]  = '{6'd16, 32'h1001,      32'd2,         32'h1002};
    vecs[6]  = '{6'd40, 32'd5,         32'd7,         32'd0};
    vecs[7]  = '{6'd2,  32'd1,         32'd33,        32'd2};
    vecs[8]  = '{6'd3,  32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[9]  = '{6'd4,  32'hFFFF_FFFF, 32'd0,         32'd0};
    vecs[10] = '{6'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[11] = '{6'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[12] = '{6'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[13] = '{6'd10, 32'd7,         32'd7,         32'd1};
    vecs[14] = '{6'd11, 32'd7,         32'd7,         32'd0};
    vecs[15] = '{6'd13, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[16] = '{6'd15, 32'hFFFF_FFFF, 32'd1,         32'd1};

    rst = 1'b1; rdy = 1'b1; clr = 1'b0; flag_alu = 1'b0; cdb_grant = 1'b0;
    op_alu = '0; rs1_alu = '0; rs2_alu = '0; rob_alu = '0;
    repeat (2) @(negedge clk);
    check("rst_flag", {31'd0, alu_ans_flag}, 32'd0);
    check("rst_ans", alu_ans, 32'd0);
    check("rst_tag", {28'd0, alu_ans_reorder}, 32'd0);
    check("rst_full", {31'd0, alu_full}, 32'd0);
    rst = 1'b0;

    // Minimum latency: ADD 5+7, tag 3.
    cdb_grant = 1'b1;
    issue(6'd0, 32'd5, 32'd7, 4'd3, 32'd12);
    @(negedge clk);
    check("lat_flag", {31'd0, alu_ans_flag}, 32'd1);
    check("lat_ans", alu_ans, 32'd12);
    check("lat_tag", {28'd0, alu_ans_reorder}, 32'd3);
    @(negedge clk);
    check("lat_flag_drop", {31'd0, alu_ans_flag}, 32'd0);

    // Op table, back-to-back with grant held.
    for (int i = 0; i < 17; i++) issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].exp);
    repeat (3) @(negedge clk);

    // Fill with grant low, then drain in order.
    cdb_grant = 1'b0;
    issue(6'd0, 32'd10, 32'd1, 4'd1, 32'd11);
    issue(6'd0, 32'd20, 32'd1, 4'd2, 32'd21);
    check("full_cnt2", {31'd0, alu_full}, 32'd0);
    issue(6'd0, 32'd30, 32'd1, 4'd3, 32'd31);
    check("full_cnt3", {31'd0, alu_full}, 32'd1);
    issue(6'd0, 32'd40, 32'd1, 4'd4, 32'd41);
    check("full_cnt4", {31'd0, alu_full}, 32'd1);
    cdb_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_flag", {31'd0, alu_ans_flag}, 32'd1);
      check("drain_tag", {28'd0, alu_ans_reorder}, 32'(k + 1));
      check("drain_full", {31'd0, alu_full}, (k == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("drain_done", {31'd0, alu_ans_flag}, 32'd0);

    // Flush with a same-edge issue.
    cdb_grant = 1'b0;
    issue(6'd0, 32'd1, 32'd4, 4'd5, 32'd5);
    issue(6'd0, 32'd1, 32'd5, 4'd6, 32'd6);
    clr = 1'b1; flag_alu = 1'b1; op_alu = 6'd0; rob_alu = 4'd7;
    sb.delete();
    @(negedge clk);
    clr = 1'b0; flag_alu = 1'b0; cdb_grant = 1'b1;
    check("clr_flag", {31'd0, alu_ans_flag}, 32'd0);
    check("clr_full", {31'd0, alu_full}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("clr_quiet", {31'd0, alu_ans_flag}, 32'd0);
    end

    // Freeze with a pending result and grant high.
    cdb_grant = 1'b0;
    issue(6'd5, 32'hFF, 32'h0F, 4'd8, 32'hF0);
    rdy = 1'b0; cdb_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("frz_flag", {31'd0, alu_ans_flag}, 32'd0);
      check("frz_ans", alu_ans, 32'd41);
      check("frz_tag", {28'd0, alu_ans_reorder}, 32'd4);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("thaw_flag", {31'd0, alu_ans_flag}, 32'd1);
    check("thaw_tag", {28'd0, alu_ans_reorder}, 32'd8);
    @(negedge clk);
    check("thaw_once", {31'd0, alu_ans_flag}, 32'd0);

    // Reset mid-queue.
    cdb_grant = 1'b0;
    issue(6'd0, 32'd9, 32'd0, 4'd9, 32'd9);
    issue(6'd0, 32'd9, 32'd1, 4'd10, 32'd10);
    issue(6'd0, 32'd9, 32'd2, 4'd11, 32'd11);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mrst_flag", {31'd0, alu_ans_flag}, 32'd0);
    check("mrst_ans", alu_ans, 32'd0);
    check("mrst_tag", {28'd0, alu_ans_reorder}, 32'd0);
    check("mrst_full", {31'd0, alu_full}, 32'd0);
    rst = 1'b0; cdb_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_quiet", {31'd0, alu_ans_flag}, 32'd0);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
